// File: rtl/pipe_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC source
// encodings and the instruction word shown when no instruction is valid.
package pipe_fetch_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,  // refetch from the current fetch PC
        PCSRC_BR  = 2'b01,  // branch target
        PCSRC_REG = 2'b10,  // register target
        PCSRC_JMP = 2'b11   // jump target
    } pcsrc_e;

    localparam logic [31:0] INS_NOP = 32'h0;

endpackage

// File: rtl/pipe_fetch_unit_if.sv
// Fetch-stage bus: instruction ROM request/response plus the
// valid/ready instruction handshake towards decode.
interface pipe_fetch_unit_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned IMEM_AW = 6
) ();

    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [XLEN-1:0]    imem_rdata;
    logic               ins_valid;
    logic               ins_ready;
    logic [XLEN-1:0]    ins;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc4;

    // fetch unit side
    modport master (
        output imem_req, imem_addr, ins_valid, ins, pc, pc4,
        input  imem_rdata, ins_ready
    );

    // ROM + decode side
    modport slave (
        input  imem_req, imem_addr, ins_valid, ins, pc, pc4,
        output imem_rdata, ins_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with push, pop and whole-queue flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign push_ok   = push & (~full | pop);
    assign pop_ok    = pop & ~empty;

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pipe_fetch_unit.sv
// Instruction-fetch stage: fetch PC, next-PC selection, 1-cycle ROM
// request tracking and a prefetch FIFO drained by decode.
module pipe_fetch_unit
    import pipe_fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     IMEM_AW    = 6,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              redirect,
    input  logic [1:0]        pcsource,
    input  logic [XLEN-1:0]   bpc,
    input  logic [XLEN-1:0]   da,
    input  logic [XLEN-1:0]   jpc,
    pipe_fetch_unit_if.master fif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0]   fpc_q, fpc_d;
    logic [XLEN-1:0]   tag_q, tag_d;
    logic              inflight_q, inflight_d;
    logic [XLEN-1:0]   target;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              fifo_empty;
    logic [2*XLEN-1:0] head;
    logic              issue;
    logic              push;
    logic              pop;

    // Redirect target selection; the sequential source refetches from fpc.
    always_comb begin
        target = fpc_q;
        case (pcsrc_e'(pcsource))
            PCSRC_SEQ: target = fpc_q;
            PCSRC_BR:  target = bpc;
            PCSRC_REG: target = da;
            PCSRC_JMP: target = jpc;
            default:   target = fpc_q;
        endcase
    end

    // Credit check counts the in-flight word, so every issued read has a FIFO slot.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue       = resetn & ~redirect & (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    // A redirect in the response cycle kills the returning wrong-path word.
    assign push        = inflight_q & ~redirect;
    assign pop         = fif.ins_valid & fif.ins_ready;

    // Next fetch PC, in-flight flag and response tag.
    always_comb begin
        fpc_d      = fpc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        if (redirect) begin
            fpc_d = {target[XLEN-1:2], 2'b00};
        end else if (issue) begin
            fpc_d      = fpc_q + XLEN'(4);
            tag_d      = fpc_q;
            inflight_d = 1'b1;
        end
    end

    // Fetch-side registers with asynchronous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fpc_q      <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (resetn),
        .push      (push),
        .push_data ({tag_q, fif.imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .head_data (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign fif.imem_req  = issue;
    assign fif.imem_addr = fpc_q[IMEM_AW+1:2];
    assign fif.ins_valid = ~fifo_empty;
    assign fif.ins       = fifo_empty ? XLEN'(INS_NOP) : head[XLEN-1:0];
    assign fif.pc        = fifo_empty ? '0 : head[2*XLEN-1:XLEN];
    assign fif.pc4       = fifo_empty ? '0 : head[2*XLEN-1:XLEN] + XLEN'(4);

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Self-checking bench for pipe_fetch_unit: reset/latency vector table,
// directed redirect/wrap/reset sequences and a randomized run against a
// queue-based reference model.
module tb_pipe_fetch_unit;

    logic        clock;
    logic        resetn;
    logic        redirect;
    logic [1:0]  pcsource;
    logic [31:0] bpc, da, jpc;
    logic        ready;
    logic [31:0] rom_q;

    int n_tests;
    int n_fail;

    pipe_fetch_unit_if #(.XLEN(32), .IMEM_AW(6)) bus ();

    pipe_fetch_unit #(
        .XLEN       (32),
        .IMEM_AW    (6),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .redirect (redirect),
        .pcsource (pcsource),
        .bpc      (bpc),
        .da       (da),
        .jpc      (jpc),
        .fif      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM word i = 0x1000_0000 + i, one-cycle read latency
    always_ff @(posedge clock) begin
        if (bus.imem_req) rom_q <= 32'h1000_0000 + {26'd0, bus.imem_addr};
    end
    assign bus.imem_rdata = rom_q;
    assign bus.ins_ready  = ready;

    // ---------------- reference model ----------------
    // FIFO contents as a queue of PCs, plus one outstanding fetch.
    logic [31:0] m_fpc;
    logic [31:0] m_q[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          m_fire, m_issue;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + ((a >> 2) % 64);
    endfunction

    task automatic model_clear();
        m_fpc  = 32'h0;
        m_q.delete();
        m_pend = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Check DUT against the model on the falling edge.
    task automatic tick_a();
        logic        v;
        logic [31:0] p;
        @(negedge clock);
        if (!resetn) model_clear();
        v       = (m_q.size() != 0);
        p       = v ? m_q[0] : 32'h0;
        m_issue = resetn && !redirect && ((m_q.size() + (m_pend ? 1 : 0)) < 4);
        m_fire  = v && ready;
        chk("model_valid", {31'd0, bus.ins_valid}, {31'd0, v});
        chk("model_pc",    bus.pc,  p);
        chk("model_ins",   bus.ins, v ? rom_word(p) : 32'h0);
        chk("model_pc4",   bus.pc4, v ? p + 32'd4 : 32'h0);
        chk("model_req",   {31'd0, bus.imem_req}, {31'd0, m_issue});
        chk("model_addr",  {26'd0, bus.imem_addr}, (m_fpc >> 2) % 64);
    endtask

    // Advance the model across the rising edge, then return 1 time unit after it.
    task automatic tick_b();
        logic [31:0] t;
        @(posedge clock);
        if (!resetn) begin
            model_clear();
        end else if (redirect) begin
            case (pcsource)
                2'b00:   t = m_fpc;
                2'b01:   t = bpc;
                2'b10:   t = da;
                default: t = jpc;
            endcase
            m_q.delete();
            m_pend = 0;
            m_fpc  = t & ~32'd3;
        end else begin
            if (m_fire) void'(m_q.pop_front());
            if (m_pend) m_q.push_back(m_pend_pc);
            m_pend = m_issue;
            if (m_issue) begin
                m_pend_pc = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic tick();
        tick_a();
        tick_b();
    endtask

    // Hold reset for two cycles, release it in the current drive window.
    task automatic do_reset();
        resetn   = 1'b0;
        redirect = 1'b0;
        model_clear();
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    // Step until ins_valid, bounded; n is the number of edges waited.
    task automatic wait_valid(input string name, input int exp_n);
        int n;
        n = 0;
        while (!bus.ins_valid && n < 12) begin
            tick();
            n++;
        end
        chk({name, "_valid"}, {31'd0, bus.ins_valid}, 32'd1);
        chk({name, "_latency"}, n, exp_n);
    endtask

    typedef struct {
        logic        rdy;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        req;
        logic [5:0]  addr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        redirect = 1'b0;
        pcsource = 2'b00;
        bpc      = '0;
        da       = '0;
        jpc      = '0;
        ready    = 1'b0;
        model_clear();

        // cycles after reset release: stalled until the FIFO fills, then drained
        tbl[0]  = '{1'b0, 1'b0, 32'h00, 32'h0,         1'b1, 6'd0};
        tbl[1]  = '{1'b0, 1'b0, 32'h00, 32'h0,         1'b1, 6'd1};
        tbl[2]  = '{1'b0, 1'b1, 32'h00, 32'h1000_0000, 1'b1, 6'd2};
        tbl[3]  = '{1'b0, 1'b1, 32'h00, 32'h1000_0000, 1'b1, 6'd3};
        tbl[4]  = '{1'b0, 1'b1, 32'h00, 32'h1000_0000, 1'b0, 6'd4};
        tbl[5]  = '{1'b0, 1'b1, 32'h00, 32'h1000_0000, 1'b0, 6'd4};
        tbl[6]  = '{1'b1, 1'b1, 32'h00, 32'h1000_0000, 1'b0, 6'd4};
        tbl[7]  = '{1'b1, 1'b1, 32'h04, 32'h1000_0001, 1'b1, 6'd4};
        tbl[8]  = '{1'b1, 1'b1, 32'h08, 32'h1000_0002, 1'b1, 6'd5};
        tbl[9]  = '{1'b1, 1'b1, 32'h0C, 32'h1000_0003, 1'b1, 6'd6};
        tbl[10] = '{1'b1, 1'b1, 32'h10, 32'h1000_0004, 1'b1, 6'd7};
        tbl[11] = '{1'b1, 1'b1, 32'h14, 32'h1000_0005, 1'b1, 6'd8};

        repeat (2) @(posedge clock);
        #1;
        chk("reset_valid", {31'd0, bus.ins_valid}, 32'd0);
        chk("reset_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("reset_pc",    bus.pc,  32'h0);
        chk("reset_pc4",   bus.pc4, 32'h0);
        chk("reset_ins",   bus.ins, 32'h0);

        // table: latency, back-pressure to exactly 4 entries, gap-free drain
        do_reset();
        for (int i = 0; i < 12; i++) begin
            ready = tbl[i].rdy;
            tick_a();
            chk($sformatf("tbl%0d_valid", i), {31'd0, bus.ins_valid}, {31'd0, tbl[i].valid});
            chk($sformatf("tbl%0d_pc", i),    bus.pc,  tbl[i].pc);
            chk($sformatf("tbl%0d_ins", i),   bus.ins, tbl[i].ins);
            chk($sformatf("tbl%0d_req", i),   {31'd0, bus.imem_req}, {31'd0, tbl[i].req});
            chk($sformatf("tbl%0d_addr", i),  {26'd0, bus.imem_addr}, {26'd0, tbl[i].addr});
            tick_b();
        end

        // branch redirect while the FIFO holds 3 entries
        do_reset();
        ready = 1'b0;
        repeat (4) tick();
        redirect = 1'b1; pcsource = 2'b01; bpc = 32'h40;
        tick();
        redirect = 1'b0;
        ready    = 1'b1;
        chk("br_flushed", {31'd0, bus.ins_valid}, 32'd0);
        wait_valid("br", 2);
        chk("br_pc",  bus.pc,  32'h40);
        chk("br_ins", bus.ins, 32'h1000_0010);
        tick();
        chk("br_pc_next", bus.pc, 32'h44);

        // register redirect right after pc=0x8 is issued; target misaligned
        do_reset();
        ready = 1'b1;
        repeat (3) tick();
        redirect = 1'b1; pcsource = 2'b10; da = 32'h23;
        chk("reg_head_pc", bus.pc, 32'h4);
        tick();
        redirect = 1'b0;
        wait_valid("reg", 2);
        chk("reg_pc",  bus.pc,  32'h20);
        chk("reg_ins", bus.ins, 32'h1000_0008);
        tick();
        chk("reg_pc_next", bus.pc, 32'h24);

        // jump redirect across the ROM address wrap
        redirect = 1'b1; pcsource = 2'b11; jpc = 32'hF8;
        tick();
        redirect = 1'b0;
        chk("wrap_addr62", {26'd0, bus.imem_addr}, 32'd62);
        tick();
        chk("wrap_addr63", {26'd0, bus.imem_addr}, 32'd63);
        tick();
        chk("wrap_addr0",  {26'd0, bus.imem_addr}, 32'd0);
        wait_valid("wrap", 0);
        chk("wrap_pc0",  bus.pc,  32'hF8);
        chk("wrap_ins0", bus.ins, 32'h1000_003E);
        tick();
        chk("wrap_pc1",  bus.pc,  32'hFC);
        chk("wrap_ins1", bus.ins, 32'h1000_003F);
        tick();
        chk("wrap_pc2",  bus.pc,  32'h100);
        chk("wrap_ins2", bus.ins, 32'h1000_0000);

        // reset mid-stream with a full FIFO, then restart from pc 0
        ready = 1'b0;
        repeat (8) tick();
        chk("full_valid", {31'd0, bus.ins_valid}, 32'd1);
        resetn = 1'b0;
        #2;
        chk("midrst_valid", {31'd0, bus.ins_valid}, 32'd0);
        chk("midrst_pc",    bus.pc, 32'h0);
        chk("midrst_req",   {31'd0, bus.imem_req}, 32'd0);
        tick();
        resetn = 1'b1;
        ready  = 1'b1;
        wait_valid("restart", 2);
        chk("restart_pc0", bus.pc,  32'h0);
        chk("restart_ins0", bus.ins, 32'h1000_0000);
        tick();
        chk("restart_pc1", bus.pc,  32'h4);
        tick();
        chk("restart_pc2", bus.pc,  32'h8);
        chk("restart_ins2", bus.ins, 32'h1000_0002);

        // randomized run against the model, including PC wrap at 2^32
        for (int i = 0; i < 600; i++) begin
            resetn   = ($urandom_range(0, 199) != 0);
            redirect = ($urandom_range(0, 9) == 0);
            pcsource = 2'($urandom_range(0, 3));
            bpc      = $urandom;
            da       = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FF00 | $urandom_range(0, 255));
            jpc      = $urandom_range(0, 511);
            ready    = ($urandom_range(0, 9) < 7);
            tick();
        end
        resetn   = 1'b1;
        redirect = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
